// File: rtl/frame_strobe_writer_if.sv
// Word stream from the bitstream loader into the column-top frame writer.
interface frame_strobe_writer_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/frame_strobe_writer.sv
// Column-top configuration writer: assembles header + NumRows data words into
// FrameData, then pulses one FrameStrobe bit with one cycle of setup and hold.
//
// state  | meaning
// IDLE   | waiting for a header word
// LOAD   | capturing data rows into FrameData
// SETUP  | FrameData stable, strobe low
// STROBE | FrameStrobe[idx] high for StrobeCycles cycles
// HOLD   | strobe low, FrameData held, frame counted
module frame_strobe_writer #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NumRows         = 4,
  parameter int StrobeCycles    = 2
) (
  input  logic                               UserCLK,
  input  logic                               resetn,
  frame_strobe_writer_if.slave               stream,
  output logic [NumRows*FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0]         FrameStrobe,
  output logic                               busy,
  output logic [15:0]                        frames_done,
  output logic                               err_sticky
);

  localparam int RowW = (NumRows > 1) ? $clog2(NumRows) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, SETUP, STROBE, HOLD} state_t;

  state_t          state_q, state_d;
  logic [4:0]      idx_q;
  logic [RowW-1:0] row_q;
  logic [3:0]      strb_q;
  logic            armed_q;
  logic            s_ready_q;
  logic            hs;
  logic            hdr_ok;
  logic            last_row;
  logic            strb_tc;

  assign stream.s_ready = s_ready_q;
  assign hs       = stream.s_valid && s_ready_q;
  assign hdr_ok   = stream.s_data[31] &&
                    ({27'd0, stream.s_data[4:0]} < 32'(MaxFramesPerCol));
  assign last_row = (row_q == RowW'(NumRows - 1));
  assign strb_tc  = (strb_q == 4'd0);

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs && hdr_ok) state_d = LOAD;
      LOAD:    if (hs && last_row) state_d = SETUP;
      SETUP:   state_d = STROBE;
      STROBE:  if (strb_tc) state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered outputs (outputs follow the next state).
  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      row_q       <= '0;
      strb_q      <= '0;
      armed_q     <= 1'b0;
      s_ready_q   <= 1'b0;
      busy        <= 1'b0;
      FrameData   <= '0;
      FrameStrobe <= '0;
      frames_done <= '0;
      err_sticky  <= 1'b0;
    end else begin
      state_q <= state_d;
      // s_ready stays low one extra edge after reset release
      armed_q   <= 1'b1;
      s_ready_q <= armed_q && ((state_d == IDLE) || (state_d == LOAD));
      busy      <= (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
      FrameStrobe <= (state_d == STROBE) ? (MaxFramesPerCol'(1) << idx_q) : '0;

      case (state_q)
        IDLE: begin
          if (hs) begin
            if (hdr_ok) begin
              idx_q <= stream.s_data[4:0];
              row_q <= '0;
            end else begin
              err_sticky <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (hs) begin
            FrameData[row_q*FrameBitsPerRow +: FrameBitsPerRow] <= stream.s_data;
            row_q <= row_q + RowW'(1);
          end
        end
        SETUP:  strb_q <= 4'(StrobeCycles - 1);
        STROBE: if (!strb_tc) strb_q <= strb_q - 4'd1;
        HOLD:   frames_done <= frames_done + 16'd1;
        default: ;
      endcase
    end
  end

endmodule
